uart_frame_tx: RTL
==================

Name: uart_frame_tx

Overview:
Parametrised UART transmitter that serialises a multi-byte word as a burst of back-to-back UART characters.
- Character format is configurable: data bits, parity, stop bits and baud divisor.
- Burst length is selectable per transfer from 1 to N_BYTES bytes.
- Sits between on-chip producers (sensor/packet logic) and the board TXD pin; data arrives over a valid/ready handshake.

Parameters:
CLK_DIV, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535
N_BYTES, 4, maximum bytes per transfer; s_data width = N_BYTES*DATA_BITS
DATA_BITS, 8, data bits per character, 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per character, 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
s_valid  in  1  producer has a transfer
s_ready  out  1  block can accept; transfer occurs when s_valid && s_ready
s_data  in  N_BYTES*DATA_BITS  payload; byte k = s_data[k*DATA_BITS +: DATA_BITS]
s_len  in  $clog2(N_BYTES+1)  bytes to send; 0 or >N_BYTES means N_BYTES
txd  out  1  serial line, idle high, registered
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset values: txd=1, s_ready=1, busy=0, done=0. Baud counter, bit counter, byte counter and state all clear.
- Reset is asynchronous at any time, including mid-character: txd returns high immediately and any partial frame is abandoned.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: s_ready=1, txd=1.
  - On accept at cycle T: latch s_data and the effective length L; byte index = L-1; baud counter = 0; go to START.
  - s_ready=0 and busy=1 from T+1.
- Bit timing:
  - Each serial bit drives txd for exactly CLK_DIV cycles.
  - The baud counter runs only while busy, counts 0..CLK_DIV-1, and advances state on wrap.
  - The first start bit appears on txd at T+1.
- Byte order: byte L-1 first, down to byte 0 (lowest L bytes, most-significant first). Bits within a byte go LSB first.
- START: txd=0, then DATA.
- DATA: DATA_BITS bits, then PAR if PARITY!=0, else STOP.
- PAR: txd = XOR of the data bits (even), or its inverse (odd).
- STOP: txd=1 for STOP_BITS bit times.
  - If byte index > 0: decrement it and go to START with no idle gap.
  - Otherwise: go to IDLE.
- Character length: B = 1 + DATA_BITS + (PARITY?1:0) + STOP_BITS. done pulses at T+1+L*B*CLK_DIV.
- In the done cycle: s_ready=1 and busy=0. An accept in that same cycle is legal and puts the next start bit on txd the following cycle (back-to-back bursts).
- s_data and s_len are ignored after the accept cycle. s_valid with s_ready=0 has no effect.
- Width rule: s_len is compared unsigned. Internal counters are sized from CLK_DIV, DATA_BITS and N_BYTES with no wrap during a legal transfer.

Test Plan:
Bench parameters unless stated: CLK_DIV=4, N_BYTES=4, DATA_BITS=8, PARITY=0, STOP_BITS=1.
1. Single byte: s_data=0x000000A5, s_len=1, accept at T.
   -> txd per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
   -> done at T+41; s_ready=0 over T+1..T+40.
2. Full word: s_data=0x12345678, s_len=0.
   -> four characters 0x12,0x34,0x56,0x78, contiguous with no gap.
   -> done at T+161; busy high over T+1..T+160.
3. Parity: PARITY=2, s_data=0x07, s_len=1 -> parity bit 1, done at T+45. PARITY=1, same data -> parity bit 0.
4. Back-to-back: s_valid held high with 0xAABBCCDD then 0x01020304, s_len=2.
   -> sends CC,DD,03,04 on txd.
   -> second start bit directly after the first burst's stop bit; s_ready high only in the done cycle.
5. Reset mid-frame: rst_n low during a data bit of byte 2 of a 4-byte burst.
   -> txd=1, s_ready=1, busy=0, done=0 immediately.
   -> after release, a new accept produces a full 4-cycle start bit and a correct burst.
6. Stability: change s_data and s_len during a transfer -> transmitted bits match the values latched at the accept cycle. STOP_BITS=2 -> stop high for 8 cycles.

Source files
------------

// File: rtl/uart_frame_tx.sv
// UART transmitter that sends the lowest L bytes of a word as back-to-back characters,
// most-significant byte first, each byte LSB first, with optional parity and 1-2 stop bits.
module uart_frame_tx #(
    parameter int CLK_DIV   = 434,
    parameter int N_BYTES   = 4,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [N_BYTES*DATA_BITS-1:0]   s_data,
    input  logic [$clog2(N_BYTES+1)-1:0]   s_len,
    output logic                           txd,
    output logic                           busy,
    output logic                           done
);

    localparam int W      = N_BYTES * DATA_BITS;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int BYTE_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int LEN_W  = $clog2(N_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q,  baud_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic [BYTE_W-1:0]   byte_q,  byte_d;
    logic [W-1:0]        data_q,  data_d;
    logic                txd_q,   txd_d;
    logic                done_q,  done_d;

    logic [LEN_W-1:0]     eff_len;
    logic [LEN_W-1:0]     len_m1;
    logic [DATA_BITS-1:0] cur_byte;
    logic [BIT_W-1:0]     bit_nx;
    logic                 baud_wrap;
    logic                 par_bit;

    // A zero or out-of-range length means a full-width burst.
    always_comb begin
        if (s_len == '0 || s_len > LEN_W'(N_BYTES)) begin
            eff_len = LEN_W'(N_BYTES);
        end else begin
            eff_len = s_len;
        end
        len_m1 = eff_len - LEN_W'(1);
    end

    assign cur_byte  = data_q[byte_q*DATA_BITS +: DATA_BITS];
    assign bit_nx    = bit_q + BIT_W'(1);
    assign baud_wrap = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign par_bit   = (PARITY == 1) ? ~(^cur_byte) : (^cur_byte);

    // txd_d always holds the level of the bit the next state will drive, so txd stays registered.
    always_comb begin
        // NOTE: every next-state signal gets a default first; otherwise the
        // untouched branches would infer latches.
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        data_d  = data_q;
        txd_d   = txd_q;
        done_d  = 1'b0;

        if (state_q == S_IDLE) begin
            txd_d = 1'b1;
            if (s_valid) begin
                data_d  = s_data;
                byte_d  = BYTE_W'(len_m1);
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
                txd_d   = 1'b0;
            end
        end else if (!baud_wrap) begin
            baud_d = baud_q + BAUD_W'(1);
        end else begin
            baud_d = '0;
            unique case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = cur_byte[0];
                end
                S_DATA: begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            txd_d   = par_bit;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nx;
                        txd_d = cur_byte[bit_nx];
                    end
                end
                S_PAR: begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end
                S_STOP: begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (byte_q != '0) begin
                            byte_d  = byte_q - BYTE_W'(1);
                            state_d = S_START;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nx;
                        txd_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
    end

    // NOTE: the payload register is reset along with the control state; it is a
    // handful of flops, not a RAM, and a clean value eases debug after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // flop samples the pre-edge value of its inputs.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign s_ready = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign txd     = txd_q;
    assign done    = done_q;

endmodule
